// File: rtl/mpc_vec_addsub_sat.sv
// rtl/mpc_vec_addsub_sat.sv - element-wise vector add/subtract engine with optional saturation
module mpc_vec_addsub_sat #(
    parameter int N        = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 32,
    parameter int A_W      = 20,
    parameter int A_SIGNED = 0,
    parameter int SAT_EN   = 1,
    parameter int CNT_W    = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              op_sub,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] a_address0,
    output logic              a_ce0,
    input  logic [A_W-1:0]    a_q0,
    output logic [ADDR_W-1:0] b_address0,
    output logic              b_ce0,
    input  logic [DATA_W-1:0] b_q0,
    output logic [ADDR_W-1:0] y_address0,
    output logic              y_ce0,
    output logic              y_we0,
    output logic [DATA_W-1:0] y_d0,
    output logic [CNT_W-1:0]  sat_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W - 1){1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              op_q, op_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  sat_cnt_q, sat_cnt_d;

    logic              a_fill;
    logic [DATA_W:0]   ea, eb, r;
    logic              sat_hit;

    // One guard bit above DATA_W makes overflow visible as a mismatch of the top two bits.
    always_comb begin
        a_fill  = (A_SIGNED != 0) && a_q0[A_W-1];
        ea      = {{(DATA_W + 1 - A_W){a_fill}}, a_q0};
        eb      = {b_q0[DATA_W-1], b_q0};
        r       = op_q ? (ea - eb) : (ea + eb);
        sat_hit = (SAT_EN != 0) && (r[DATA_W] ^ r[DATA_W-1]);
    end

    always_comb begin
        ap_idle    = (state_q == S_IDLE);
        ap_done    = (state_q == S_DONE);
        ap_ready   = (state_q == S_RUN) && (idx_q == LAST_IDX);
        a_ce0      = (state_q == S_RUN);
        b_ce0      = a_ce0;
        a_address0 = a_ce0 ? idx_q : '0;
        b_address0 = a_address0;
        y_ce0      = valid_q;
        y_we0      = valid_q;
        y_address0 = valid_q ? wr_addr_q : '0;
        y_d0       = '0;
        if (valid_q) begin
            if (sat_hit) y_d0 = r[DATA_W] ? MIN_NEG : MAX_POS;
            else         y_d0 = r[DATA_W-1:0];
        end
        sat_cnt    = sat_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        valid_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        sat_cnt_d = sat_cnt_q;
        if (valid_q && sat_hit) sat_cnt_d = sat_cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    op_d      = op_sub;
                    idx_d     = '0;
                    sat_cnt_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                valid_d   = 1'b1;
                wr_addr_d = idx_q;
                if (idx_q == LAST_IDX) state_d = S_DRAIN;
                else                   idx_d   = idx_q + ADDR_W'(1);
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_addr_q <= '0;
            op_q      <= 1'b0;
            valid_q   <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_addr_q <= wr_addr_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_mpc_vec_addsub_sat.sv
// tb/tb_mpc_vec_addsub_sat.sv - bench for mpc_vec_addsub_sat over three parameter sets
module tb_mpc_vec_addsub_sat;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start [NI];
    logic        op    [NI];
    logic        done  [NI];
    logic        idle  [NI];
    logic        ready [NI];
    logic        a_ce  [NI];
    logic        b_ce  [NI];
    logic        y_ce  [NI];
    logic        y_we  [NI];
    logic [3:0]  a_addr[NI];
    logic [3:0]  b_addr[NI];
    logic [3:0]  y_addr[NI];
    logic [3:0]  sat   [NI];
    logic [19:0] a_q   [NI];
    logic [31:0] b_q   [NI];
    logic [31:0] y_d   [NI];

    logic [19:0] amem[NI][16];
    logic [31:0] bmem[NI][16];
    logic [31:0] ymem[NI][16];

    logic [2:0] a_adr0, b_adr0, y_adr0;
    logic [3:0] a_adr1, b_adr1, y_adr1, sat0, sat1;
    logic       a_adr2, b_adr2, y_adr2, sat2;

    mpc_vec_addsub_sat u_d0 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start[0]), .op_sub(op[0]),
        .ap_done(done[0]), .ap_idle(idle[0]), .ap_ready(ready[0]),
        .a_address0(a_adr0), .a_ce0(a_ce[0]), .a_q0(a_q[0]),
        .b_address0(b_adr0), .b_ce0(b_ce[0]), .b_q0(b_q[0]),
        .y_address0(y_adr0), .y_ce0(y_ce[0]), .y_we0(y_we[0]), .y_d0(y_d[0]),
        .sat_cnt(sat0)
    );

    mpc_vec_addsub_sat #(.N(13), .ADDR_W(4), .A_SIGNED(1), .SAT_EN(0)) u_d1 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start[1]), .op_sub(op[1]),
        .ap_done(done[1]), .ap_idle(idle[1]), .ap_ready(ready[1]),
        .a_address0(a_adr1), .a_ce0(a_ce[1]), .a_q0(a_q[1]),
        .b_address0(b_adr1), .b_ce0(b_ce[1]), .b_q0(b_q[1]),
        .y_address0(y_adr1), .y_ce0(y_ce[1]), .y_we0(y_we[1]), .y_d0(y_d[1]),
        .sat_cnt(sat1)
    );

    mpc_vec_addsub_sat #(.N(1), .ADDR_W(1), .A_SIGNED(1), .SAT_EN(1), .CNT_W(1)) u_d2 (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start[2]), .op_sub(op[2]),
        .ap_done(done[2]), .ap_idle(idle[2]), .ap_ready(ready[2]),
        .a_address0(a_adr2), .a_ce0(a_ce[2]), .a_q0(a_q[2]),
        .b_address0(b_adr2), .b_ce0(b_ce[2]), .b_q0(b_q[2]),
        .y_address0(y_adr2), .y_ce0(y_ce[2]), .y_we0(y_we[2]), .y_d0(y_d[2]),
        .sat_cnt(sat2)
    );

    assign a_addr[0] = {1'b0, a_adr0};
    assign b_addr[0] = {1'b0, b_adr0};
    assign y_addr[0] = {1'b0, y_adr0};
    assign a_addr[1] = a_adr1;
    assign b_addr[1] = b_adr1;
    assign y_addr[1] = y_adr1;
    assign a_addr[2] = {3'b0, a_adr2};
    assign b_addr[2] = {3'b0, b_adr2};
    assign y_addr[2] = {3'b0, y_adr2};
    assign sat[0]    = sat0;
    assign sat[1]    = sat1;
    assign sat[2]    = {3'b0, sat2};

    // Operand memories with one cycle of read latency.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (a_ce[k]) a_q[k] <= amem[k][a_addr[k]];
            if (b_ce[k]) b_q[k] <= bmem[k][b_addr[k]];
        end
    end

    int n_cmp;
    int n_err;

    function automatic int nvec(input int k);
        return (k == 0) ? 8 : (k == 1) ? 13 : 1;
    endfunction

    function automatic bit a_sgn(input int k);
        return k != 0;
    endfunction

    function automatic bit sat_on(input int k);
        return k != 1;
    endfunction

    // Exact integer arithmetic, then clamp or wrap into 32 bits.
    function automatic void model(input int k, input bit opv, input logic [19:0] a,
                                  input logic [31:0] b, output logic [31:0] y, output bit s);
        longint va, vb, r;
        va = longint'(a);
        if (a_sgn(k) && a[19]) va = va - 64'sd1048576;
        vb = longint'($signed(b));
        r  = opv ? va - vb : va + vb;
        s  = 1'b0;
        if (sat_on(k) && r > 64'sd2147483647) begin
            y = 32'h7FFF_FFFF; s = 1'b1;
        end else if (sat_on(k) && r < -64'sd2147483648) begin
            y = 32'h8000_0000; s = 1'b1;
        end else begin
            y = r[31:0];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_y(input int k);
        for (int i = 0; i < 16; i++) ymem[k][i] = 'x;
    endtask

    // One run on instance k, starting from an IDLE cycle; cycle 0 is the accept cycle.
    task automatic run(input int k, input bit opv, output int done_at, output int ready_at,
                       output int nwr, output bit order_ok);
        int c;
        done_at = -1; ready_at = -1; nwr = 0; order_ok = 1'b1; c = 0;
        @(negedge clk);
        if (!idle[k]) order_ok = 1'b0;
        start[k] = 1'b1;
        op[k]    = opv;
        while (c < 60) begin
            @(negedge clk);
            c++;
            start[k] = 1'($urandom_range(0, 1));
            op[k]    = 1'($urandom_range(0, 1));
            if (y_ce[k] && y_we[k]) begin
                ymem[k][y_addr[k]] = y_d[k];
                if (int'(y_addr[k]) != nwr || c != nwr + 2) order_ok = 1'b0;
                nwr++;
            end
            if (ready[k]) ready_at = c;
            if (done[k]) begin
                done_at = c;
                break;
            end
        end
        start[k] = 1'b0;
    endtask

    typedef struct {
        int          k;
        bit          opv;
        logic [19:0] a;
        logic [31:0] b;
        logic [31:0] y;
        int          nsat;
    } vec_t;

    vec_t vt[8];

    initial begin
        int          d_at, r_at, nw, c, ndone, nsat_exp;
        int          dones[2];
        bit          ok, s;
        logic [31:0] ye;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0;
            op[k]    = 1'b0;
        end

        vt[0] = '{0, 1'b1, 20'h00000, 32'h8000_0000, 32'h7FFF_FFFF, 8};
        vt[1] = '{0, 1'b0, 20'hFFFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 8};
        vt[2] = '{2, 1'b0, 20'h80000, 32'h8000_0000, 32'h8000_0000, 1};
        vt[3] = '{1, 1'b0, 20'h80000, 32'h8000_0000, 32'h7FF8_0000, 0};
        vt[4] = '{0, 1'b1, 20'h00000, 32'h0000_0001, 32'hFFFF_FFFF, 0};
        vt[5] = '{0, 1'b0, 20'hFFFFF, 32'h0000_0001, 32'h0010_0000, 0};
        vt[6] = '{2, 1'b1, 20'hFFFFF, 32'h0000_0000, 32'hFFFF_FFFF, 0};
        vt[7] = '{1, 1'b1, 20'h00000, 32'h8000_0000, 32'h8000_0000, 0};

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_idle", idle[k], 1);
            chk("rst_done", done[k], 0);
            chk("rst_ready", ready[k], 0);
            chk("rst_ce", {a_ce[k], b_ce[k], y_ce[k], y_we[k]}, 0);
            chk("rst_addr", {a_addr[k], b_addr[k], y_addr[k]}, 0);
            chk("rst_sat", sat[k], 0);
        end
        rst_n = 1'b1;

        // Ramp minus constant on the default instance.
        for (int i = 0; i < 8; i++) begin
            amem[0][i] = 20'(i * 32'h1000);
            bmem[0][i] = 32'h10;
        end
        clear_y(0);
        run(0, 1'b1, d_at, r_at, nw, ok);
        chk("p1_done_at", d_at, 10);
        chk("p1_ready_at", r_at, 8);
        chk("p1_nwr", nw, 8);
        chk("p1_order", ok, 1);
        chk("p1_y0", ymem[0][0], 32'hFFFF_FFF0);
        for (int i = 0; i < 8; i++) chk("p1_y", ymem[0][i], 32'(i * 32'h1000 - 32'h10));
        chk("p1_sat", sat[0], 0);
        @(negedge clk);
        chk("p1_done_one", done[0], 0);
        chk("p1_idle_after", idle[0], 1);

        // Directed vectors: every element carries the same operands.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < nvec(vt[v].k); i++) begin
                amem[vt[v].k][i] = vt[v].a;
                bmem[vt[v].k][i] = vt[v].b;
            end
            clear_y(vt[v].k);
            run(vt[v].k, vt[v].opv, d_at, r_at, nw, ok);
            chk("vec_done_at", d_at, nvec(vt[v].k) + 2);
            chk("vec_ready_at", r_at, nvec(vt[v].k));
            chk("vec_order", ok, 1);
            chk("vec_nwr", nw, nvec(vt[v].k));
            for (int i = 0; i < nvec(vt[v].k); i++) chk("vec_y", ymem[vt[v].k][i], vt[v].y);
            chk("vec_sat", sat[vt[v].k], vt[v].nsat);
        end

        // Randomized runs against the arithmetic model.
        for (int it = 0; it < 12; it++) begin
            int  k;
            bit  opv;
            k   = it % NI;
            opv = 1'($urandom_range(0, 1));
            for (int i = 0; i < nvec(k); i++) begin
                amem[k][i] = 20'($urandom);
                case ($urandom_range(0, 3))
                    0:       bmem[k][i] = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
                    1:       bmem[k][i] = 32'h8000_0000 + 32'($urandom_range(0, 3));
                    default: bmem[k][i] = $urandom;
                endcase
            end
            clear_y(k);
            run(k, opv, d_at, r_at, nw, ok);
            nsat_exp = 0;
            for (int i = 0; i < nvec(k); i++) begin
                model(k, opv, amem[k][i], bmem[k][i], ye, s);
                if (s) nsat_exp++;
                chk("rand_y", ymem[k][i], ye);
            end
            chk("rand_sat", sat[k], nsat_exp);
            chk("rand_done_at", d_at, nvec(k) + 2);
            chk("rand_order", ok, 1);
        end

        // Start held high: back-to-back runs, sat_cnt cleared on each accept.
        for (int i = 0; i < 8; i++) begin
            amem[0][i] = 20'h0;
            bmem[0][i] = (i % 2 == 0) ? 32'h8000_0000 : 32'h10;
        end
        @(negedge clk);
        start[0] = 1'b1;
        op[0]    = 1'b1;
        c = 0; ndone = 0;
        dones[0] = -1; dones[1] = -1;
        while (c < 40 && ndone < 2) begin
            @(negedge clk);
            c++;
            if (done[0]) begin
                dones[ndone] = c;
                ndone++;
            end
            if (c == 10) chk("b2b_sat_hold", sat[0], 4);
            if (c == 11) begin
                chk("b2b_idle_gap", idle[0], 1);
                chk("b2b_sat_gap", sat[0], 4);
            end
            if (c == 12) chk("b2b_sat_clr", sat[0], 0);
        end
        start[0] = 1'b0;
        chk("b2b_done1", dones[0], 10);
        chk("b2b_done2", dones[1], 21);
        chk("b2b_sat_end", sat[0], 4);

        // Asynchronous reset in cycle 4 of a run, then a clean rerun.
        for (int i = 0; i < 8; i++) begin
            amem[0][i] = 20'(i * 32'h1000);
            bmem[0][i] = 32'h10;
        end
        @(negedge clk);
        start[0] = 1'b1;
        op[0]    = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_ce", a_ce[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ce", {a_ce[0], b_ce[0], y_ce[0], y_we[0]}, 0);
        chk("arst_idle", idle[0], 1);
        chk("arst_ready", ready[0], 0);
        chk("arst_sat", sat[0], 0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_no_done", done[0], 0);
            chk("arst_no_we", y_we[0], 0);
        end
        rst_n = 1'b1;
        clear_y(0);
        run(0, 1'b1, d_at, r_at, nw, ok);
        chk("post_rst_done_at", d_at, 10);
        chk("post_rst_nwr", nw, 8);
        chk("post_rst_order", ok, 1);
        chk("post_rst_y7", ymem[0][7], 32'h0000_6FF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
